// File: rtl/uart_frame_tx.sv
// UART link frame encoder: SOF, LEN, TYPE, payload, CRC-8 (poly 0x07).
// Bytes leave through a single registered holding stage toward the UART.
module uart_frame_tx #(
   parameter int MAX_PAYLOAD = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_valid,
   output logic       frame_ready,
   input  logic [7:0] frame_len,
   input  logic [7:0] frame_type,
   input  logic       pl_valid,
   output logic       pl_ready,
   input  logic [7:0] pl_byte,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_byte,
   output logic       busy,
   output logic       done,
   output logic       len_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_LEN,
      S_TYPE,
      S_PAYLOAD,
      S_CRC,
      S_DRAIN
   } state_t;

   state_t     state, state_nx;
   logic [7:0] len_q, type_q, crc_q, idx_q;
   logic [7:0] len_nx, type_nx, crc_nx, idx_nx, byte_nx;
   logic       load, load_ok, len_bad, done_nx, err_nx;

   function automatic logic [7:0] crc8_upd(input logic [7:0] c,
                                           input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++)
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   assign load_ok     = !tx_valid || tx_ready;
   assign len_bad     = int'(frame_len) > MAX_PAYLOAD;
   assign frame_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);

   always_comb begin
      state_nx = state;
      len_nx   = len_q;
      type_nx  = type_q;
      crc_nx   = crc_q;
      idx_nx   = idx_q;
      byte_nx  = tx_byte;
      load     = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      pl_ready = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (frame_valid) begin
               len_nx  = frame_len;
               type_nx = frame_type;
               crc_nx  = 8'h00;
               idx_nx  = 8'h00;
               if (len_bad) begin
                  err_nx = 1'b1;
               end else if (load_ok) begin
                  // SOF goes out on the accept edge itself
                  load     = 1'b1;
                  byte_nx  = 8'hA5;
                  state_nx = S_LEN;
               end else begin
                  state_nx = S_SOF;
               end
            end
         end
         S_SOF: begin
            if (load_ok) begin
               load     = 1'b1;
               byte_nx  = 8'hA5;
               state_nx = S_LEN;
            end
         end
         S_LEN: begin
            if (load_ok) begin
               load     = 1'b1;
               byte_nx  = len_q;
               crc_nx   = crc8_upd(crc_q, len_q);
               state_nx = S_TYPE;
            end
         end
         S_TYPE: begin
            if (load_ok) begin
               load     = 1'b1;
               byte_nx  = type_q;
               crc_nx   = crc8_upd(crc_q, type_q);
               state_nx = (len_q == 8'h00) ? S_CRC : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            pl_ready = load_ok;
            if (pl_valid && load_ok) begin
               load    = 1'b1;
               byte_nx = pl_byte;
               crc_nx  = crc8_upd(crc_q, pl_byte);
               // equality test keeps LEN=255 from wrapping early
               if (idx_q == len_q - 8'd1)
                  state_nx = S_CRC;
               else
                  idx_nx = idx_q + 8'd1;
            end
         end
         S_CRC: begin
            if (load_ok) begin
               load     = 1'b1;
               byte_nx  = crc_q;
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (tx_valid && tx_ready) begin
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         len_q   <= 8'h00;
         type_q  <= 8'h00;
         crc_q   <= 8'h00;
         idx_q   <= 8'h00;
         tx_valid <= 1'b0;
         tx_byte <= 8'h00;
         done    <= 1'b0;
         len_err <= 1'b0;
      end else begin
         state   <= state_nx;
         len_q   <= len_nx;
         type_q  <= type_nx;
         crc_q   <= crc_nx;
         idx_q   <= idx_nx;
         done    <= done_nx;
         len_err <= err_nx;
         if (load) begin
            tx_valid <= 1'b1;
            tx_byte  <= byte_nx;
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: framing, CRC, stalls, length
// rejection and asynchronous reset mid-frame.
module tb_uart_frame_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fv0 = 1'b0, fv16 = 1'b0;
   logic [7:0] frame_len = 8'h00, frame_type = 8'h00;
   logic       pl_valid = 1'b0;
   logic [7:0] pl_byte = 8'h00;
   logic       tx_ready = 1'b1;

   logic       fr0, plr0, tv0, busy0, done0, lerr0;
   logic [7:0] tb0;
   logic       fr16, plr16, tv16, busy16, done16, lerr16;
   logic [7:0] tb16;

   logic       sel = 1'b0;
   logic       m_fr, m_plr, m_tv, m_busy, m_done;
   logic [7:0] m_tb;

   assign m_fr   = sel ? fr16   : fr0;
   assign m_plr  = sel ? plr16  : plr0;
   assign m_tv   = sel ? tv16   : tv0;
   assign m_busy = sel ? busy16 : busy0;
   assign m_done = sel ? done16 : done0;
   assign m_tb   = sel ? tb16   : tb0;

   uart_frame_tx dut (
      .clk(clk), .rst_n(rst_n),
      .frame_valid(fv0), .frame_ready(fr0),
      .frame_len(frame_len), .frame_type(frame_type),
      .pl_valid(pl_valid), .pl_ready(plr0), .pl_byte(pl_byte),
      .tx_valid(tv0), .tx_ready(tx_ready), .tx_byte(tb0),
      .busy(busy0), .done(done0), .len_err(lerr0)
   );

   uart_frame_tx #(.MAX_PAYLOAD(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .frame_valid(fv16), .frame_ready(fr16),
      .frame_len(frame_len), .frame_type(frame_type),
      .pl_valid(pl_valid), .pl_ready(plr16), .pl_byte(pl_byte),
      .tx_valid(tv16), .tx_ready(tx_ready), .tx_byte(tb16),
      .busy(busy16), .done(done16), .len_err(lerr16)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;
   logic [7:0] tab [256];
   logic [7:0] pay [256];
   logic [7:0] got [$];
   int t_acc, t_first, t_last, t_done, n_done, n_plr, n_stab;
   logic d_busy, d_fr;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic run_frame(input logic s, input int len,
                            input logic [7:0] typ, input bit gap);
      int pi, k;
      logic stall_prev, seen;
      logic [7:0] prev_b;
      got.delete();
      sel = s;
      t_first = -1; t_last = -1; t_done = -1;
      n_done = 0; n_plr = 0; n_stab = 0;
      pi = 0; stall_prev = 1'b0; prev_b = 8'h00; seen = 1'b0;
      @(negedge clk);
      frame_len = len[7:0]; frame_type = typ;
      tx_ready = 1'b1; pl_valid = 1'b0;
      if (s) fv16 = 1'b1; else fv0 = 1'b1;
      k = 0;
      while (!m_fr && k < 50) begin @(negedge clk); k++; end
      t_acc = cyc + 1;
      for (k = 0; k < 3000 && !seen; k++) begin
         @(negedge clk);
         fv0 = 1'b0; fv16 = 1'b0;
         if (stall_prev && (!m_tv || m_tb != prev_b)) n_stab++;
         if (m_done) begin
            n_done++; t_done = cyc; seen = 1'b1;
            d_busy = m_busy; d_fr = m_fr;
         end else begin
            tx_ready = gap ? (k % 2 == 0) : 1'b1;
            pl_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            pl_byte  = pay[pi];
            #1;
            if (m_plr) n_plr++;
            stall_prev = m_tv && !tx_ready;
            prev_b = m_tb;
            if (m_tv && tx_ready) begin
               got.push_back(m_tb);
               if (t_first < 0) t_first = cyc + 1;
               t_last = cyc + 1;
            end
            if (pl_valid && m_plr && pi < 255) pi++;
         end
      end
      chk("frame_timeout", int'(seen), 1);
      pl_valid = 1'b0; tx_ready = 1'b1;
   endtask

   task automatic cmp_frame(input string tag, input int len,
                            input logic [7:0] typ);
      logic [7:0] e [$];
      logic [7:0] c;
      c = 8'h00;
      e.push_back(8'hA5);
      e.push_back(len[7:0]); c = tab[c ^ len[7:0]];
      e.push_back(typ);      c = tab[c ^ typ];
      for (int i = 0; i < len; i++) begin
         e.push_back(pay[i]); c = tab[c ^ pay[i]];
      end
      e.push_back(c);
      chk({tag, "_count"}, got.size(), e.size());
      for (int i = 0; i < e.size(); i++)
         chk($sformatf("%s_b%0d", tag, i),
             (i < got.size()) ? int'(got[i]) : 32'hDEAD, int'(e[i]));
   endtask

   task automatic chk_timing(input string tag, input int len);
      chk({tag, "_first"}, t_first - t_acc, 1);
      chk({tag, "_last"}, t_last - t_acc, len + 4);
      chk({tag, "_done_at"}, t_done, t_last);
      chk({tag, "_done_n"}, n_done, 1);
      chk({tag, "_busy_after"}, int'(d_busy), 0);
      chk({tag, "_ready_after"}, int'(d_fr), 1);
   endtask

   initial begin
      int n, errs, k;
      logic [7:0] c;
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin
         b = i[7:0];
         for (int j = 0; j < 8; j++)
            b = b[7] ? ((b << 1) ^ 8'h07) : (b << 1);
         tab[i] = b;
         pay[i] = 8'h00;
      end

      // reset values
      #12;
      chk("rst_tx_valid", int'(tv0), 0);
      chk("rst_tx_byte", int'(tb0), 0);
      chk("rst_pl_ready", int'(plr0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_len_err", int'(lerr0), 0);
      chk("rst_frame_ready", int'(fr0), 1);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // LEN=0, TYPE=0x01
      run_frame(1'b0, 0, 8'h01, 1'b0);
      cmp_frame("len0", 0, 8'h01);
      chk("len0_crc", (got.size() == 4) ? int'(got[3]) : -1, 8'h07);
      chk_timing("len0", 0);
      chk("len0_pl_ready", n_plr, 0);

      // LEN=1, TYPE=0x01, payload 0x02
      pay[0] = 8'h02;
      run_frame(1'b0, 1, 8'h01, 1'b0);
      cmp_frame("len1", 1, 8'h01);
      chk("len1_crc", (got.size() == 5) ? int'(got[4]) : -1, 8'h70);
      chk_timing("len1", 1);
      chk("len1_pl_ready", n_plr, 1);

      // LEN=3 with tx_ready toggling and gapped payload
      pay[0] = 8'h3C; pay[1] = 8'hFF; pay[2] = 8'h81;
      run_frame(1'b0, 3, 8'h42, 1'b0);
      cmp_frame("len3", 3, 8'h42);
      run_frame(1'b0, 3, 8'h42, 1'b1);
      cmp_frame("len3_gap", 3, 8'h42);
      chk("len3_gap_stable", n_stab, 0);
      chk("len3_gap_done_n", n_done, 1);

      // LEN=255 with random payload
      for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
      run_frame(1'b0, 255, 8'h9E, 1'b0);
      cmp_frame("len255", 255, 8'h9E);
      chk_timing("len255", 255);
      c = 8'h00; errs = 0;
      for (int i = 1; i + 1 < got.size(); i++) c = tab[c ^ got[i]];
      for (int i = 0; i < 255; i++)
         if (got.size() != 259 || got[3 + i] != pay[i]) errs++;
      chk("rx_crc_ok", (got.size() == 259 && got[0] == 8'hA5 &&
                        got[1] == 8'hFF && got[258] == c) ? 1 : 0, 1);
      chk("rx_payload", errs, 0);

      // MAX_PAYLOAD=16 instance: LEN=17 is dropped
      sel = 1'b1;
      @(negedge clk);
      frame_len = 8'd17; frame_type = 8'h05; fv16 = 1'b1;
      chk("lerr_ready", int'(fr16), 1);
      n = 0; errs = 0;
      for (k = 0; k < 6; k++) begin
         @(negedge clk);
         fv16 = 1'b0;
         if (lerr16) n++;
         if (tv16 || busy16) errs++;
         if (k == 0) chk("lerr_next_cycle", int'(lerr16), 1);
      end
      chk("lerr_pulses", n, 1);
      chk("lerr_no_tx", errs, 0);
      pay[0] = 8'h11; pay[1] = 8'h22;
      run_frame(1'b1, 2, 8'h07, 1'b0);
      cmp_frame("max16_len2", 2, 8'h07);
      chk_timing("max16_len2", 2);

      // reset while payload byte 5 of 10 is on the wire
      sel = 1'b0;
      for (int i = 0; i < 10; i++) pay[i] = 8'(8'h60 + i);
      @(negedge clk);
      frame_len = 8'd10; frame_type = 8'h33; fv0 = 1'b1;
      tx_ready = 1'b1; pl_valid = 1'b1;
      n = 0;
      for (k = 0; k < 40 && n < 5; k++) begin
         @(negedge clk);
         fv0 = 1'b0;
         pl_byte = pay[n];
         #1;
         if (plr0) n++;
      end
      chk("rst_reach_byte5", n, 5);
      @(posedge clk); #2;
      chk("pre_rst_busy", int'(busy0), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_valid", int'(tv0), 0);
      chk("mid_rst_busy", int'(busy0), 0);
      pl_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", int'(fr0), 1);
      chk("post_rst_tx_valid", int'(tv0), 0);
      pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
      run_frame(1'b0, 4, 8'h21, 1'b0);
      cmp_frame("post_rst", 4, 8'h21);
      chk_timing("post_rst", 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
